mdu: RTL and testbench

- Multiply/divide unit in the EX stage, in parallel with the ALU; driven by the same forwarded ID/EX operands.
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, holds the architectural HI/LO registers and services MTHI/MTLO.
- Its busy output feeds the hazard unit, which stalls MD/MF instructions in ID.
- MD_result is muxed with ALU_result into the EX/MEM register.

---
 rtl/mdu_if.sv | 25 ++
 rtl/mdu.sv | 125 ++++++++++++
 tb/tb_mdu.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// Multiply/divide unit bus: EX-stage operands and control in, status and HI/LO out.
interface mdu_if;
  logic        start;
  logic [2:0]  MDOp;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic        MFSel;
  logic        busy;
  logic        done;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic [31:0] MD_result;

  // Pipeline side drives the operation, reads back status and HI/LO
  modport master (
    output start, MDOp, inputA, inputB, MFSel,
    input  busy, done, HI_out, LO_out, MD_result
  );

  // The multiply/divide unit itself
  modport slave (
    input  start, MDOp, inputA, inputB, MFSel,
    output busy, done, HI_out, LO_out, MD_result
  );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU plus MTHI/MTLO,
// owning the architectural HI/LO registers. The result is computed at accept
// into hidden pending registers and committed when the latency counter expires.
module mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave md
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [31:0]      hi_reg;
  logic [31:0]      lo_reg;
  logic [31:0]      pend_hi_reg;
  logic [31:0]      pend_lo_reg;
  logic             pend_wr_reg;

  logic [63:0] smul;
  logic [63:0] umul;
  logic [31:0] div_b;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        is_md;
  logic        is_div;

  // Full-width result of the operation presented this cycle
  always_comb begin
    // Low 64 bits of the sign-extended product equal the signed 64-bit product
    smul     = {{32{md.inputA[31]}}, md.inputA} * {{32{md.inputB[31]}}, md.inputB};
    umul     = {32'd0, md.inputA} * {32'd0, md.inputB};
    div_zero = (md.inputB == 32'd0);
    // Substitute a harmless divisor so the divider never sees zero; the result is discarded anyway
    div_b    = div_zero ? 32'd1 : md.inputB;
    div_ovf  = (md.inputA == 32'h8000_0000) && (md.inputB == 32'hFFFF_FFFF);
    sq       = $signed(md.inputA) / $signed(div_b);
    sr       = $signed(md.inputA) % $signed(div_b);
    uq       = md.inputA / div_b;
    ur       = md.inputA % div_b;
    is_md    = (md.MDOp >= OP_MULT) && (md.MDOp <= OP_DIVU);
    is_div   = (md.MDOp == OP_DIV) || (md.MDOp == OP_DIVU);
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    case (md.MDOp)
      OP_MULT:  {res_hi, res_lo} = smul;
      OP_MULTU: {res_hi, res_lo} = umul;
      OP_DIV: begin
        // Most-negative / -1 overflows the quotient; it wraps to itself with zero remainder
        res_hi = div_ovf ? 32'd0 : sr;
        res_lo = div_ovf ? 32'h8000_0000 : sq;
      end
      OP_DIVU: begin
        res_hi = ur;
        res_lo = uq;
      end
      default: ;
    endcase
  end

  // Accept, count down, commit pending HI/LO and handle MTHI/MTLO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pend_hi_reg <= 32'd0;
      pend_lo_reg <= 32'd0;
      pend_wr_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (cnt_reg != '0) begin
        // In flight: every new request is ignored until the counter drains
        cnt_reg <= cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
          if (pend_wr_reg) begin
            hi_reg <= pend_hi_reg;
            lo_reg <= pend_lo_reg;
          end
        end
      end else if (md.start) begin
        if (is_md) begin
          pend_hi_reg <= res_hi;
          pend_lo_reg <= res_lo;
          pend_wr_reg <= !(is_div && div_zero);
          cnt_reg     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          busy_reg    <= 1'b1;
        end else if (md.MDOp == OP_MTHI) begin
          hi_reg <= md.inputA;
        end else if (md.MDOp == OP_MTLO) begin
          lo_reg <= md.inputA;
        end
      end
    end
  end

  assign md.busy      = busy_reg;
  assign md.done      = done_reg;
  assign md.HI_out    = hi_reg;
  assign md.LO_out    = lo_reg;
  assign md.MD_result = md.MFSel ? hi_reg : lo_reg;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: directed vector table, hand-written corner sequences and
// randomized operations checked against an arithmetic model of HI/LO.
module tb_mdu;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;
  localparam int NV    = 10;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] hi_m;
  logic [31:0] lo_m;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          scramble;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tv [NV];

  mdu_if u_if ();

  mdu #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Architectural effect of one accepted operation, from plain 64-bit arithmetic
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (op)
      3'd1: begin p = sa * sb; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; hi_m = r[31:0]; lo_m = q[31:0]; end
      3'd4: if (b != 32'd0) begin hi_m = a % b; lo_m = a / b; end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endtask

  // Compare HI/LO and both MD_result selections with the model
  task automatic check_regs(input string tag);
    check({tag, "_hi"}, u_if.HI_out, hi_m);
    check({tag, "_lo"}, u_if.LO_out, lo_m);
    u_if.MFSel = 1'b0;
    #1;
    check({tag, "_mdres_lo"}, u_if.MD_result, lo_m);
    u_if.MFSel = 1'b1;
    #1;
    check({tag, "_mdres_hi"}, u_if.MD_result, hi_m);
  endtask

  // Issue one operation; for mult/div count busy cycles and verify the done pulse
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble);
    int n;
    int want;
    u_if.start  = 1'b1;
    u_if.MDOp   = op;
    u_if.inputA = a;
    u_if.inputB = b;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    if (op >= 3'd1 && op <= 3'd4) begin
      want = (op >= 3'd3) ? DIV_N : MUL_N;
      n = 0;
      while (u_if.busy && n < 200) begin
        check("done_low_while_busy", 32'(u_if.done), 32'd0);
        n++;
        if (scramble) begin
          u_if.start  = 1'($urandom_range(0, 1));
          u_if.MDOp   = 3'($urandom_range(0, 7));
          u_if.inputA = $urandom;
          u_if.inputB = $urandom;
        end
        @(posedge clk);
        #1;
      end
      u_if.start = 1'b0;
      check("busy_cycles", 32'(n), 32'(want));
      check("done_pulse", 32'(u_if.done), 32'd1);
    end else begin
      check("no_busy_mt", 32'(u_if.busy), 32'd0);
      check("no_done_mt", 32'(u_if.done), 32'd0);
    end
    $display("op=%0d a=0x%08h b=0x%08h -> HI=0x%08h LO=0x%08h", op, a, b, u_if.HI_out, u_if.LO_out);
  endtask

  initial begin
    int n;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    tv[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tv[1] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    tv[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tv[3] = '{3'd4, 32'd7,         32'd0,        1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tv[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000};
    tv[5] = '{3'd5, 32'h0000_DEAD, 32'd0,        1'b0, 32'h0000_DEAD, 32'h8000_0000};
    tv[6] = '{3'd6, 32'h0000_BEEF, 32'd0,        1'b0, 32'h0000_DEAD, 32'h0000_BEEF};
    tv[7] = '{3'd4, 32'd100,       32'd7,        1'b0, 32'd2,         32'd14};
    tv[8] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 1'b1, 32'd1,         32'hFFFF_FFFD};
    tv[9] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000};

    reset       = 1'b0;
    u_if.start  = 1'b0;
    u_if.MDOp   = 3'd0;
    u_if.inputA = 32'd0;
    u_if.inputB = 32'd0;
    u_if.MFSel  = 1'b0;
    hi_m = 32'd0;
    lo_m = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(u_if.busy), 32'd0);
    check("rst_done", 32'(u_if.done), 32'd0);
    check("rst_hi", u_if.HI_out, 32'd0);
    check("rst_lo", u_if.LO_out, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      do_op(tv[i].op, tv[i].a, tv[i].b, tv[i].scramble);
      check("tbl_hi", u_if.HI_out, tv[i].exp_hi);
      check("tbl_lo", u_if.LO_out, tv[i].exp_lo);
      model_apply(tv[i].op, tv[i].a, tv[i].b);
      @(posedge clk);
      #1;
      check("done_one_cycle", 32'(u_if.done), 32'd0);
    end

    // DIV in flight with a stray MTLO at busy cycle 3, then MTHI in the done cycle
    u_if.start  = 1'b1;
    u_if.MDOp   = 3'd3;
    u_if.inputA = 32'd100;
    u_if.inputB = 32'd3;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("seq_busy_c3", 32'(u_if.busy), 32'd1);
    u_if.start  = 1'b1;
    u_if.MDOp   = 3'd6;
    u_if.inputA = 32'h1234;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    n = 0;
    while (!u_if.done && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("seq_done_seen", 32'(u_if.done), 32'd1);
    model_apply(3'd3, 32'd100, 32'd3);
    check("seq_div_lo", u_if.LO_out, 32'd33);
    u_if.start  = 1'b1;
    u_if.MDOp   = 3'd5;
    u_if.inputA = 32'hABCD;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    model_apply(3'd5, 32'hABCD, 32'd0);
    check("seq_mthi_busy", 32'(u_if.busy), 32'd0);
    check("seq_mthi_hi", u_if.HI_out, 32'hABCD);
    check_regs("seq");
    $display("seq div+mthi -> HI=0x%08h LO=0x%08h", u_if.HI_out, u_if.LO_out);

    // Randomized operations against the model, back-to-back from the done cycle
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      do_op(rop, ra, rb, 1'($urandom_range(0, 1)));
      model_apply(rop, ra, rb);
      check_regs("rand");
    end

    // Reset pulled low at busy cycle 2 of a MULT
    @(posedge clk);
    #1;
    u_if.start  = 1'b1;
    u_if.MDOp   = 3'd1;
    u_if.inputA = 32'd5;
    u_if.inputB = 32'd6;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(u_if.busy), 32'd0);
    check("midrst_done", 32'(u_if.done), 32'd0);
    check("midrst_hi", u_if.HI_out, 32'd0);
    check("midrst_lo", u_if.LO_out, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      check("postrst_no_done", 32'(u_if.done), 32'd0);
      check("postrst_no_busy", 32'(u_if.busy), 32'd0);
    end
    check_regs("postrst");
    $display("reset mid-MULT -> HI=0x%08h LO=0x%08h", u_if.HI_out, u_if.LO_out);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
